// File: rtl/pe_vnu_block.sv
// LDPC PE memory block: intrinsic/decision storage plus the J-input variable-node update pass.
// Optional build macro PE_VNU_DEC_CHANGE_EN adds the per-pass decision-flip counter.
module pe_vnu_block #(
  parameter int J             = 3,
  parameter int ADDR_WIDTH    = 5,
  parameter int MESSAGE_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_valid,
  input  logic [ADDR_WIDTH-1:0]           load_add_in,
  input  logic [MESSAGE_WIDTH-1:0]        int_in,
  input  logic                            start,
  input  logic                            cnu_valid,
  input  logic [J*MESSAGE_WIDTH-1:0]      cnu_data_in,
  output logic                            vnu_valid,
  output logic [ADDR_WIDTH-1:0]           vnu_add_out,
  output logic [J*MESSAGE_WIDTH-1:0]      vnu_data_out,
  output logic                            dec_out,
  output logic                            busy,
  output logic                            done,
  input  logic [ADDR_WIDTH-1:0]           read_add_in,
  output logic                            dec_rd,
  output logic [ADDR_WIDTH:0]             dec_changes
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int MW        = MESSAGE_WIDTH;
  localparam int TW        = MW + $clog2(J + 1) + 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_COL = {ADDR_WIDTH{1'b1}};
  localparam logic signed [TW-1:0]  SAT_HI   = TW'((1 << (MW - 1)) - 1);
  localparam logic signed [TW-1:0]  SAT_LO   = -SAT_HI;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // Symmetric clamp: the most negative code is never emitted.
  function automatic logic signed [MW-1:0] sat_msg(input logic signed [TW-1:0] v);
    if (v > SAT_HI) begin
      return SAT_HI[MW-1:0];
    end else if (v < SAT_LO) begin
      return SAT_LO[MW-1:0];
    end else begin
      return v[MW-1:0];
    end
  endfunction

  logic [1:0]                state;
  logic [ADDR_WIDTH-1:0]     cnt;
  logic                      accept;

  logic signed [MW-1:0]      int_ram [RAM_DEPTH];
  logic [RAM_DEPTH-1:0]      dec_mem;

  logic                      vld_p0;
  logic [J*MW-1:0]           msg_p0;
  logic signed [MW-1:0]      int_p0;
  logic [ADDR_WIDTH-1:0]     addr_p0;

  logic signed [TW-1:0]      total_c;
  logic [J*MW-1:0]           ext_c;
  logic                      dec_c;

  assign accept = (state == S_RUN) && cnu_valid;
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          if (cnu_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_COL) begin
              state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (done) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A write coinciding with start lands before the first RUN-cycle read.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && load_valid) begin
      int_ram[load_add_in] <= int_in;
    end
  end

  // ---- stage p0: capture column, read intrinsic ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      msg_p0  <= cnu_data_in;
      int_p0  <= int_ram[cnt];
      addr_p0 <= cnt;
    end
  end

  always_comb begin
    total_c = TW'(int_p0);
    for (int i = 0; i < J; i++) begin
      total_c = total_c + TW'(signed'(msg_p0[i*MW +: MW]));
    end
    ext_c = '0;
    for (int i = 0; i < J; i++) begin
      ext_c[i*MW +: MW] = sat_msg(total_c - TW'(signed'(msg_p0[i*MW +: MW])));
    end
    dec_c = total_c[TW-1];
  end

  // ---- stage p1: registered results ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vnu_valid    <= 1'b0;
      done         <= 1'b0;
      vnu_add_out  <= '0;
      vnu_data_out <= '0;
      dec_out      <= 1'b0;
    end else begin
      vnu_valid <= vld_p0;
      done      <= vld_p0 && (addr_p0 == LAST_COL);
      if (vld_p0) begin
        vnu_add_out  <= addr_p0;
        vnu_data_out <= ext_c;
        dec_out      <= dec_c;
      end
    end
  end

  // Read port samples before the write, so a same-address collision returns the old bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_mem <= '0;
      dec_rd  <= 1'b0;
    end else begin
      if (vld_p0) begin
        dec_mem[addr_p0] <= dec_c;
      end
      dec_rd <= dec_mem[read_add_in];
    end
  end

`ifdef PE_VNU_DEC_CHANGE_EN
  logic                  dec_old_p0;
  logic [ADDR_WIDTH:0]   dec_cnt;

  // Each column is visited once per pass, so this read never races its own write.
  always_ff @(posedge clk) begin
    if (accept) begin
      dec_old_p0 <= dec_mem[cnt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_cnt <= '0;
    end else if ((state == S_IDLE) && start) begin
      dec_cnt <= '0;
    end else if (vld_p0 && (dec_c != dec_old_p0)) begin
      dec_cnt <= dec_cnt + 1'b1;
    end
  end

  assign dec_changes = dec_cnt;
`else
  assign dec_changes = '0;
`endif

endmodule

// File: tb/tb_pe_vnu_block.sv
// Directed bench for pe_vnu_block (J=3, ADDR_WIDTH=5, MESSAGE_WIDTH=5).
`timescale 1ns/1ps
module tb_pe_vnu_block;
  localparam int J     = 3;
  localparam int AW    = 5;
  localparam int MW    = 5;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_valid;
  logic [AW-1:0]     load_add_in;
  logic [MW-1:0]     int_in;
  logic              start;
  logic              cnu_valid;
  logic [J*MW-1:0]   cnu_data_in;
  logic              vnu_valid;
  logic [AW-1:0]     vnu_add_out;
  logic [J*MW-1:0]   vnu_data_out;
  logic              dec_out;
  logic              busy;
  logic              done;
  logic [AW-1:0]     read_add_in;
  logic              dec_rd;
  logic [AW:0]       dec_changes;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int drv_cyc [DEPTH];
  bit prev_dec[DEPTH];

  pe_vnu_block #(.J(J), .ADDR_WIDTH(AW), .MESSAGE_WIDTH(MW)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_add_in(load_add_in),
    .int_in(int_in), .start(start), .cnu_valid(cnu_valid), .cnu_data_in(cnu_data_in),
    .vnu_valid(vnu_valid), .vnu_add_out(vnu_add_out), .vnu_data_out(vnu_data_out),
    .dec_out(dec_out), .busy(busy), .done(done), .read_add_in(read_add_in),
    .dec_rd(dec_rd), .dec_changes(dec_changes)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_flip(input int a);
    return (a == 3) || (a == 7) || (a == 20);
  endfunction

  function automatic int ival(input int a, input bit f);
    int v;
    if (a == 0) v = 4;
    else if (a == 1) v = 15;
    else if (a == 2) v = -15;
    else v = ((a * 7) % 13) - 6;
    return (f && is_flip(a)) ? -v : v;
  endfunction

  function automatic int mval(input int a, input int i, input bit f);
    int v;
    if (a == 0) v = (i == 0) ? 3 : ((i == 1) ? -2 : 1);
    else if (a == 1) v = 15;
    else if (a == 2) v = -15;
    else if (i == 0) v = ((a * 5) % 17) - 8;
    else if (i == 1) v = ((a * 3) % 9) - 4;
    else v = -(a % 7);
    return (f && is_flip(a)) ? -v : v;
  endfunction

  function automatic int clamp15(input int v);
    if (v > 15) return 15;
    if (v < -15) return -15;
    return v;
  endfunction

  function automatic int total(input int a, input bit f);
    int t;
    t = ival(a, f);
    for (int i = 0; i < J; i++) t = t + mval(a, i, f);
    return t;
  endfunction

  function automatic logic [J*MW-1:0] exp_data(input int a, input bit f);
    logic [J*MW-1:0] e;
    int x;
    e = '0;
    for (int i = 0; i < J; i++) begin
      x = clamp15(total(a, f) - mval(a, i, f));
      e[i*MW +: MW] = x[MW-1:0];
    end
    return e;
  endfunction

  function automatic logic [J*MW-1:0] pack_cnu(input int a, input bit f);
    logic [J*MW-1:0] p;
    int x;
    p = '0;
    for (int i = 0; i < J; i++) begin
      x = mval(a, i, f);
      p[i*MW +: MW] = x[MW-1:0];
    end
    return p;
  endfunction

  task automatic load_and_start(input bit f);
    int v;
    for (int a = 1; a < DEPTH; a++) begin
      v = ival(a, f);
      load_valid = 1'b1; load_add_in = AW'(a); int_in = v[MW-1:0];
      tick();
    end
    load_add_in = '0; int_in = 5'b10111;
    tick();
    v = ival(0, f);
    load_add_in = '0; int_in = v[MW-1:0]; start = 1'b1;
    tick();
    load_valid = 1'b0; start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic scan_dec(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      read_add_in = AW'(a);
      tick();
      check(tag, 64'(dec_rd), 64'(prev_dec[a]));
    end
  endtask

  task automatic run_pass(input bit f);
    bit new_dec[DEPTH];
    int exp_chg;
    int want;
    int got_n;
    bit chk_new;
    exp_chg = 0; got_n = 0; chk_new = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      new_dec[a] = (total(a, f) < 0);
      if (new_dec[a] != prev_dec[a]) exp_chg++;
    end
    read_add_in = AW'(7);
    load_and_start(f);
    fork
      begin
        for (int a = 0; a < DEPTH; a++) begin
          int gap;
          gap = ((a * 7) % 4 == 0) ? 1 : ((a == 15) ? 3 : 0);
          repeat (gap) begin
            cnu_valid = 1'b0;
            tick();
          end
          cnu_valid = 1'b1; cnu_data_in = pack_cnu(a, f); drv_cyc[a] = cyc;
          tick();
        end
        cnu_valid = 1'b0;
      end
      begin
        for (int n = 0; n < 400 && got_n < DEPTH; n++) begin
          tick();
          if (chk_new) begin
            check("dec_rd_new", 64'(dec_rd), 64'(new_dec[7]));
            chk_new = 1'b0;
          end
          if (vnu_valid) begin
            check("latency", 64'(cyc), 64'(drv_cyc[got_n] + 2));
            check("addr", 64'(vnu_add_out), 64'(got_n));
            check("data", 64'(vnu_data_out), 64'(exp_data(got_n, f)));
            check("dec", 64'(dec_out), 64'(new_dec[got_n]));
            check("done", 64'(done), 64'(got_n == DEPTH - 1));
            check("busy_run", 64'(busy), 64'd1);
            if (got_n == 0) check("basic_vnu", 64'(vnu_data_out), 64'({5'd5, 5'd8, 5'd3}));
            if (got_n == 1) check("sat_pos", 64'({dec_out, vnu_data_out}), 64'({1'b0, 5'd15, 5'd15, 5'd15}));
            if (got_n == 2) check("sat_neg", 64'({dec_out, vnu_data_out}), 64'({1'b1, 5'b10001, 5'b10001, 5'b10001}));
            if (got_n == 7) begin
              check("dec_rd_old", 64'(dec_rd), 64'(prev_dec[7]));
              chk_new = 1'b1;
            end
            got_n++;
          end
        end
        check("result_count", 64'(got_n), 64'(DEPTH));
      end
    join
    tick();
    check("busy_drop", 64'(busy), 64'd0);
    check("done_pulse", 64'(done), 64'd0);
    want = exp_chg;
`ifndef PE_VNU_DEC_CHANGE_EN
    want = 0;
`endif
    check("dec_changes", 64'(dec_changes), 64'(want));
    for (int a = 0; a < DEPTH; a++) prev_dec[a] = new_dec[a];
    scan_dec("dec_mem");
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_add_in = '0; int_in = '0; start = 1'b0;
    cnu_valid = 1'b0; cnu_data_in = '0; read_add_in = '0;
    tick();
    tick();
    check("rst_vnu_valid", 64'(vnu_valid), 64'd0);
    check("rst_addr", 64'(vnu_add_out), 64'd0);
    check("rst_data", 64'(vnu_data_out), 64'd0);
    check("rst_dec_out", 64'(dec_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dec_rd", 64'(dec_rd), 64'd0);
    check("rst_dec_changes", 64'(dec_changes), 64'd0);
    rst = 1'b0;
    for (int a = 0; a < DEPTH; a++) prev_dec[a] = 1'b0;

    run_pass(1'b0);
    run_pass(1'b1);

    load_and_start(1'b0);
    for (int a = 0; a <= 10; a++) begin
      cnu_valid = 1'b1; cnu_data_in = pack_cnu(a, 1'b0);
      if (a == 10) rst = 1'b1;
      tick();
    end
    check("midrst_idle", 64'(busy), 64'd0);
    check("midrst_vld", 64'(vnu_valid), 64'd0);
    tick();
    rst = 1'b0;
    check("midrst_outs", 64'({vnu_valid, vnu_add_out, vnu_data_out, dec_out, done, busy, dec_rd}), 64'd0);
    check("midrst_chg", 64'(dec_changes), 64'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("idle_ignore", 64'({vnu_valid, done, busy}), 64'd0);
    end
    cnu_valid = 1'b0;
    for (int a = 0; a < DEPTH; a++) prev_dec[a] = 1'b0;
    scan_dec("midrst_mem");
    run_pass(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
